// File: rtl/inv_cov_2.sv
// Inverse covariance B = L^-T * L^-1 from the packed 2x2 inverse-Cholesky matrix S,
// using one shared pipelined multiplier. Define INV_COV_SATURATE_EN for saturating arithmetic.
module inv_cov_2 #(
    parameter int MULT_LAT = 7,
    parameter int DW       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3*DW-1:0] S,
    input  logic            S_valid,
    output logic            S_ready,
    output logic [3*DW-1:0] B,
    output logic            B_valid,
    input  logic            B_ready
);

    // Handshake: a word moves on a rising edge where valid and ready are both high;
    // a producer holds valid and keeps its payload stable until that edge.

    localparam int FB = DW / 2;

    localparam logic [5:0] C_P1  = 6'(1 + MULT_LAT);
    localparam logic [5:0] C_P2  = 6'(2 + MULT_LAT);
    localparam logic [5:0] C_T   = 6'(3 + MULT_LAT);
    localparam logic [5:0] C_OP4 = 6'(4 + MULT_LAT);
    localparam logic [5:0] C_U   = 6'(4 + 2 * MULT_LAT);
    localparam logic [5:0] C_OP5 = 6'(5 + 2 * MULT_LAT);
    localparam logic [5:0] C_OP6 = 6'(6 + 2 * MULT_LAT);
    localparam logic [5:0] C_V   = 6'(5 + 3 * MULT_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STAGE1,
        S_STAGE2,
        S_STAGE3,
        S_SUM,
        S_OUT
    } state_t;

    state_t        state, state_nxt;
    logic [5:0]    cnt;
    logic [DW-1:0] d1, l21, d2;
    logic [DW-1:0] p1, p2, t, u, v;
    logic [DW-1:0] b11, b21, b22;
    logic [DW-1:0] mul_a, mul_b, prod;
    logic [DW-1:0] pipe [MULT_LAT];
    logic [DW-1:0] mout;

    function automatic logic [DW-1:0] q_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [2*DW-1:0] ae, be, p;
        ae = {{DW{a[DW-1]}}, a};
        be = {{DW{b[DW-1]}}, b};
        p  = ae * be;
`ifdef INV_COV_SATURATE_EN
        if (p[2*DW-1:DW+FB-1] != {(FB+1){p[2*DW-1]}})
            return p[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
        return p[DW+FB-1:FB];
    endfunction

    function automatic logic [DW-1:0] q_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef INV_COV_SATURATE_EN
        logic [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1])
            return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return s[DW-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [DW-1:0] q_neg(input logic [DW-1:0] a);
`ifdef INV_COV_SATURATE_EN
        if (a == {1'b1, {(DW-1){1'b0}}})
            return {1'b0, {(DW-1){1'b1}}};
`endif
        return {DW{1'b0}} - a;
    endfunction

    assign prod = q_mul(mul_a, mul_b);
    assign mout = pipe[MULT_LAT-1];
    assign B    = {b22, b21, b11};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (S_valid)      state_nxt = S_STAGE1;
            S_STAGE1: if (cnt == C_T)   state_nxt = S_STAGE2;
            S_STAGE2: if (cnt == C_U)   state_nxt = S_STAGE3;
            S_STAGE3: if (cnt == C_V)   state_nxt = S_SUM;
            S_SUM:                      state_nxt = S_OUT;
            S_OUT:    if (B_ready)      state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // cnt equals the number of cycles since acceptance; every issue and capture keys off it.
    always_comb begin
        S_ready = (state == S_IDLE);
        B_valid = (state == S_OUT);
        mul_a   = '0;
        mul_b   = '0;
        case (state)
            S_STAGE1: begin
                if (cnt == 6'd1)      begin mul_a = d1;  mul_b = d1; end
                else if (cnt == 6'd2) begin mul_a = d2;  mul_b = d2; end
                else if (cnt == 6'd3) begin mul_a = l21; mul_b = d1; end
            end
            S_STAGE2: begin
                if (cnt == C_OP4)     begin mul_a = t;   mul_b = d2; end
            end
            S_STAGE3: begin
                if (cnt == C_OP5)     begin mul_a = u;   mul_b = d2; end
                else if (cnt == C_OP6) begin mul_a = u;  mul_b = u;  end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            d1  <= '0; l21 <= '0; d2 <= '0;
            p1  <= '0; p2  <= '0; t  <= '0; u <= '0; v <= '0;
            b11 <= '0; b21 <= '0; b22 <= '0;
            for (int i = 0; i < MULT_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= prod;
            for (int i = 1; i < MULT_LAT; i++) pipe[i] <= pipe[i-1];

            if (state == S_IDLE)     cnt <= 6'd1;
            else if (state != S_OUT) cnt <= cnt + 6'd1;

            case (state)
                S_IDLE: begin
                    if (S_valid) begin
                        d1  <= S[DW-1:0];
                        l21 <= S[2*DW-1:DW];
                        d2  <= S[3*DW-1:2*DW];
                    end
                end
                S_STAGE1: begin
                    if (cnt == C_P1) p1 <= mout;
                    if (cnt == C_P2) p2 <= mout;
                    if (cnt == C_T)  t  <= mout;
                end
                S_STAGE2: if (cnt == C_U) u <= mout;
                S_STAGE3: if (cnt == C_V) v <= mout;
                S_SUM: begin
                    // w is at the multiplier output during this cycle.
                    b11 <= q_add(p1, mout);
                    b21 <= q_neg(v);
                    b22 <= p2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_cov_2.sv
// Directed and randomised checks of inv_cov_2: results, latency, back-pressure,
// back-to-back throughput, overflow behaviour and mid-operation reset.
module tb_inv_cov_2;

    localparam int L  = 7;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] S;
    logic        S_valid;
    logic        S_ready;
    logic [95:0] B;
    logic        B_valid;
    logic        B_ready;

    always #5 clk = ~clk;

    inv_cov_2 #(.MULT_LAT(L), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .S       (S),
        .S_valid (S_valid),
        .S_ready (S_ready),
        .B       (B),
        .B_valid (B_valid),
        .B_ready (B_ready)
    );

    logic [95:0] exp_q[$];
    logic [95:0] exp_next;
    int n_cmp = 0, n_fail = 0;
    int cyc = 0, n_acc = 0, n_out = 0;
    int last_acc = 0, last_hs = 0, rise_cyc = 0;

    // Reference arithmetic written from the numeric definition of Q16.16.
    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'(int'(a)) * longint'(int'(b));
`ifdef INV_COV_SATURATE_EN
        if (p >= (longint'(1) <<< 47))  return 32'h7FFFFFFF;
        if (p <  -(longint'(1) <<< 47)) return 32'h80000000;
`endif
        return p[47:16];
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'(int'(a)) + longint'(int'(b));
`ifdef INV_COV_SATURATE_EN
        if (s > 64'sd2147483647)  return 32'h7FFFFFFF;
        if (s < -64'sd2147483648) return 32'h80000000;
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] m_neg(input logic [31:0] a);
`ifdef INV_COV_SATURATE_EN
        if (a == 32'h80000000) return 32'h7FFFFFFF;
`endif
        return 32'h0 - a;
    endfunction

    function automatic logic [95:0] model(input logic [95:0] s);
        logic [31:0] d1, l21, d2, p1, p2, t, u, v, w;
        d1 = s[31:0]; l21 = s[63:32]; d2 = s[95:64];
        p1 = m_mul(d1, d1);
        p2 = m_mul(d2, d2);
        t  = m_mul(l21, d1);
        u  = m_mul(t, d2);
        v  = m_mul(u, d2);
        w  = m_mul(u, u);
        return {p2, m_neg(v), m_add(p1, w)};
    endfunction

    function automatic logic [95:0] rand_s();
        logic [31:0] d1, l21, d2;
        d1  = $urandom_range(32'h00030000, 32'h00004000);
        l21 = $urandom_range(32'h00040000, 32'h0) - 32'h00020000;
        d2  = $urandom_range(32'h00030000, 32'h00004000);
        return {d2, l21, d1};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: scoreboard push on acceptance, pop/compare on output handshake.
    task automatic tick();
        logic acc, hs, bv_before;
        int   pre;
        acc       = S_valid && S_ready;
        hs        = B_valid && B_ready;
        bv_before = B_valid;
        pre       = cyc;
        if (acc) exp_q.push_back(exp_next);
        if (hs) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL spurious_out: observed %h expected no output", B);
            end else begin
                chk("b_out", B, exp_q.pop_front());
            end
            n_out++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin n_acc++; last_acc = pre; end
        if (hs) last_hs = pre;
        if (B_valid && !bv_before) rise_cyc = cyc;
    endtask

    task automatic wait_acc(input string tag);
        int target;
        target = n_acc + 1;
        for (int i = 0; i < 200 && n_acc < target; i++) tick();
        chk(tag, 96'(n_acc), 96'(target));
    endtask

    task automatic wait_out(input int target, input string tag);
        for (int i = 0; i < 200 && n_out < target; i++) tick();
        chk(tag, 96'(n_out), 96'(target));
    endtask

    task automatic run_one(input logic [95:0] s, input logic [95:0] e, input string tag);
        int target;
        target   = n_out + 1;
        S        = s;
        exp_next = e;
        S_valid  = 1'b1;
        wait_acc(tag);
        S_valid  = 1'b0;
        wait_out(target, tag);
    endtask

    localparam logic [95:0] S_IDENT = {32'h00010000, 32'h00000000, 32'h00010000};
    localparam logic [95:0] B_IDENT = {32'h00010000, 32'h00000000, 32'h00010000};
    localparam logic [95:0] S_A422  = {32'h00010000, 32'h00010000, 32'h00008000};
    localparam logic [95:0] B_A422  = {32'h00010000, 32'hFFFF8000, 32'h00008000};
    localparam logic [95:0] S_DIAG  = {32'h00008000, 32'h00000000, 32'h00010000};
    localparam logic [95:0] B_DIAG  = {32'h00004000, 32'h00000000, 32'h00010000};
    localparam logic [95:0] S_OVF   = {32'h00010000, 32'h00000000, 32'h01000000};
`ifdef INV_COV_SATURATE_EN
    localparam logic [95:0] B_OVF   = {32'h00010000, 32'h00000000, 32'h7FFFFFFF};
`else
    localparam logic [95:0] B_OVF   = {32'h00010000, 32'h00000000, 32'h00000000};
`endif

    initial begin
        int a1, a2, base, seen;
        logic [95:0] rs;

        rst = 1'b1; S = '0; S_valid = 1'b0; B_ready = 1'b0; exp_next = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_b",       B,              96'd0);
        chk("rst_b_valid", 96'(B_valid),   96'd0);
        chk("rst_s_ready", 96'(S_ready),   96'd1);

        // Identity, with first-result latency counted from the acceptance cycle.
        B_ready = 1'b1;
        run_one(S_IDENT, B_IDENT, "identity");
        chk("latency", 96'(rise_cyc - last_acc), 96'(7 + 3 * L));

        run_one(S_A422, B_A422, "a_4_2_2");

        // Back-pressure: result and ready held, new input refused until after handshake.
        B_ready  = 1'b0;
        S        = S_DIAG;
        exp_next = B_DIAG;
        S_valid  = 1'b1;
        wait_acc("diag_acc");
        S_valid  = 1'b0;
        for (int i = 0; i < 200 && !B_valid; i++) tick();
        chk("diag_bvalid", 96'(B_valid), 96'd1);
        a1       = n_acc;
        S        = S_IDENT;
        exp_next = B_IDENT;
        S_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_b",       B,              B_DIAG);
            chk("hold_s_ready", 96'(S_ready),   96'd0);
            chk("hold_b_valid", 96'(B_valid),   96'd1);
        end
        chk("hold_no_accept", 96'(n_acc), 96'(a1));
        B_ready = 1'b1;
        tick();
        chk("b_retained", B, B_DIAG);
        wait_acc("post_hs_acc");
        chk("accept_after_hs", 96'(last_acc - last_hs), 96'd1);
        S_valid = 1'b0;
        wait_out(n_out + 1, "post_hs_out");

        // Back-to-back with S_valid held high.
        base     = n_out;
        S        = S_A422;
        exp_next = B_A422;
        S_valid  = 1'b1;
        wait_acc("b2b_acc1");
        a1       = last_acc;
        rs       = rand_s();
        S        = rs;
        exp_next = model(rs);
        wait_acc("b2b_acc2");
        a2       = last_acc;
        S_valid  = 1'b0;
        chk("b2b_spacing", 96'(a2 - a1), 96'(8 + 3 * L));
        wait_out(base + 2, "b2b_out");

        run_one(S_OVF, B_OVF, "overflow");

        // Reset in cycle 10 of an operation discards the work in flight.
        S        = S_A422;
        exp_next = B_A422;
        S_valid  = 1'b1;
        wait_acc("rst_mid_acc");
        S_valid  = 1'b0;
        a1       = last_acc;
        while (cyc < a1 + 10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_b",       B,            96'd0);
        chk("mid_rst_b_valid", 96'(B_valid), 96'd0);
        chk("mid_rst_s_ready", 96'(S_ready), 96'd1);
        exp_q.delete();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (B_valid) seen++;
        end
        chk("no_partial_out", 96'(seen), 96'd0);
        run_one(S_A422, B_A422, "after_rst");

        for (int i = 0; i < 3; i++) begin
            rs = rand_s();
            run_one(rs, model(rs), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_cov_2.md
Name: inv_cov_2

Overview:
- Consumes the packed 2x2 "Inverse-Cholesky" matrix S produced by the upstream 2x2 inverse-Cholesky block and produces the packed lower triangle of the inverse covariance B = A^-1 = L^-T * L^-1.
- S carries d1 = 1/L11, L21 and d2 = 1/L22, so no division or square root is needed, only multiplies, one add and one negate.
- A single shared pipelined multiplier is sequenced by an FSM.
- Sits downstream of the inverse-Cholesky block in the filter covariance path, with valid/ready handshakes on both sides.

Parameters:
- MULT_LAT, 7, pipeline depth of the internal multiplier in cycles (legal range 1..15).
- DW, 32, element width, signed Q16.16 fixed point; not intended to change.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- S  in  96  packed input: [31:0]=d1 (S11), [63:32]=L21 (S21), [95:64]=d2 (S22)
- S_valid  in  1  input valid
- S_ready  out  1  input ready; high only in S_IDLE
- B  out  96  packed output: [31:0]=B11, [63:32]=B21, [95:64]=B22
- B_valid  out  1  output valid; held until accepted
- B_ready  in  1  downstream ready

Behaviour:
- Reset: state=S_IDLE, B=0, B_valid=0, S_ready=1. All internal operand and result registers are cleared.
- Acceptance: S is captured when S_valid & S_ready. This is cycle 0. S_ready drops in cycle 1.
- Arithmetic:
  - Each product is the signed 64-bit a*b; the result is bits [47:16].
  - The add is a 32-bit signed add.
  - The negate is two's complement.
  - Overflow wraps unless SATURATE_EN is defined.
- Multiplier: operands presented in cycle k give a result captured in cycle k+MULT_LAT. That result may be used as an operand in cycle k+MULT_LAT+1. Operands are presented at most once per cycle.
- Issue schedule (L = MULT_LAT):
  - op1 d1*d1 -> p1, cycle 1
  - op2 d2*d2 -> p2, cycle 2
  - op3 L21*d1 -> t, cycle 3
  - op4 t*d2 -> u, cycle 4+L
  - op5 u*d2 -> v, cycle 5+2L
  - op6 u*u -> w, cycle 6+2L
- Results:
  - B22 = p2
  - B21 = -v
  - B11 = p1 + w, registered
- Output timing: B and B_valid update in cycle 7+3L, which is 28 for L=7.
- FSM states:
  - S_IDLE -> S_STAGE1 on acceptance.
  - S_STAGE1 issues op1..op3, then waits for t.
  - S_STAGE2 issues op4, then waits for u.
  - S_STAGE3 issues op5 and op6, then waits for w.
  - S_SUM registers B11 and sets B_valid.
  - S_OUT holds.
  - S_OUT -> S_IDLE when B_ready is sampled high.
  - A single cycle counter (>=6 bits) times all waits.
- Output handshake:
  - B is stable while B_valid=1.
  - B_valid clears in the cycle after the B_valid & B_ready handshake.
  - S_ready returns to 1 in that same cycle.
  - If B_ready is already high when B_valid rises, the transfer completes in 1 cycle. The next acceptance can occur in cycle 8+3L, giving a throughput of 1 matrix per 8+3L cycles.
  - B retains its last value after transfer until the next result overwrites it.
- S_valid while busy: ignored, because S_ready=0. S is not re-sampled mid-operation.
- Reset mid-operation: returns to S_IDLE on the next edge and clears B and B_valid. No partial result is ever emitted. In-flight multiplier results are discarded, because the counter and state restart.

Optional Feature:
- Macro: INV_COV_SATURATE_EN.
- Defined:
  - Each product whose bits [63:47] are not all equal saturates to 0x7FFFFFFF if positive or 0x80000000 if negative.
  - The B11 add saturates on signed overflow.
  - The negate of 0x80000000 gives 0x7FFFFFFF.
- Not defined: plain truncation and wrap, with no extra logic. Latency is identical in both builds.

Test Plan:
- Identity: S={d1=0x00010000, L21=0, d2=0x00010000} -> B={0x00010000, 0x00000000, 0x00010000}, with B_valid rising exactly 7+3L cycles after acceptance.
- A=[[4,2],[2,2]]: S={0x00008000, 0x00010000, 0x00010000} -> B={0x00008000, 0xFFFF8000, 0x00010000}, i.e. [[0.5,-0.5],[-0.5,1]].
- Diagonal A=[[1,0],[0,4]]: S={0x00010000, 0, 0x00008000} -> B={0x00010000, 0, 0x00004000}. Then hold B_ready=0 for 10 cycles: B stays stable, S_ready stays 0, and a new S_valid is not accepted until 1 cycle after the handshake.
- Back-to-back: S_valid held high with two matrices and B_ready=1 -> the second is accepted at cycle 8+3L after the first, and both results are correct.
- Overflow: S={0x01000000, 0, 0x00010000} -> B11=0x00000000 without the macro, and B11=0x7FFFFFFF with INV_COV_SATURATE_EN. B21=0 and B22=0x00010000 in both builds.
- Reset: assert rst for 1 cycle at cycle 10 of an operation -> B_valid=0, B=0 and S_ready=1 on the next cycle, and the next operation produces a correct result.
